// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/invalidate/redirect control for an in-order pipeline with trap flush and WFI sleep.
// Optional WFI sleep state is built only when KLEINE_WFI_SLEEP_EN is defined.
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid_decode,
  input  logic [4:0] i_rs1_address_decode,
  input  logic [4:0] i_rs2_address_decode,
  input  logic       i_valid_execute,
  input  logic       i_load_execute,
  input  logic [4:0] i_rd_address_execute,
  input  logic       i_branch_taken_execute,
  input  logic       i_mem_busy,
  input  logic       i_valid_writeback,
  input  logic       i_trap_writeback,
  input  logic       i_mret_writeback,
  input  logic       i_wfi_writeback,
  input  logic       i_interrupt_pending,
  output logic       o_stall_fetch,
  output logic       o_stall_decode,
  output logic       o_stall_execute,
  output logic       o_stall_memory,
  output logic       o_invalidate_fetch,
  output logic       o_invalidate_decode,
  output logic       o_invalidate_execute,
  output logic       o_invalidate_memory,
  output logic       o_redirect,
  output logic       o_sleeping
);

  typedef enum logic [1:0] {RUN, FLUSH, SLEEP} state_t;

  state_t     r_state;
  logic [2:0] r_flush_cnt;
  logic       r_sleeping;

  logic w_trap;
  logic w_wfi;
  logic w_branch;
  logic w_load_use;

  assign w_trap   = i_valid_writeback & (i_trap_writeback | i_mret_writeback);
  assign w_branch = i_branch_taken_execute & i_valid_execute;
  assign w_load_use = i_valid_decode & i_valid_execute & i_load_execute &
                      (i_rd_address_execute != 5'd0) &
                      ((i_rd_address_execute == i_rs1_address_decode) |
                       (i_rd_address_execute == i_rs2_address_decode));

`ifdef KLEINE_WFI_SLEEP_EN
  assign w_wfi = i_valid_writeback & i_wfi_writeback & ~w_trap;
`else
  // WFI retires as a plain NOP when sleep support is not built.
  logic w_unused_wfi;
  assign w_wfi        = 1'b0;
  assign w_unused_wfi = i_wfi_writeback;
`endif

  assign o_sleeping = r_sleeping;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= RUN;
      r_flush_cnt <= 3'd0;
      r_sleeping  <= 1'b0;
    end else begin
      r_sleeping <= 1'b0;
      if (w_trap) begin
        r_state     <= FLUSH;
        r_flush_cnt <= 3'(FLUSH_CYCLES);
      end else if (w_wfi) begin
        r_state    <= SLEEP;
        r_sleeping <= 1'b1;
      end else begin
        case (r_state)
          FLUSH: begin
            if (r_flush_cnt < 3'd2) begin
              r_state     <= RUN;
              r_flush_cnt <= 3'd0;
            end else begin
              r_flush_cnt <= r_flush_cnt - 3'd1;
            end
          end
          SLEEP: begin
            // Wake only; the interrupt itself arrives later as a trap at writeback.
            if (i_interrupt_pending) r_state <= RUN;
            else                     r_sleeping <= 1'b1;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  always_comb begin
    o_stall_fetch        = 1'b0;
    o_stall_decode       = 1'b0;
    o_stall_execute      = 1'b0;
    o_stall_memory       = 1'b0;
    o_invalidate_fetch   = 1'b0;
    o_invalidate_decode  = 1'b0;
    o_invalidate_execute = 1'b0;
    o_invalidate_memory  = 1'b0;
    o_redirect           = 1'b0;
    if (i_reset || w_trap || w_wfi) begin
      o_invalidate_fetch   = 1'b1;
      o_invalidate_decode  = 1'b1;
      o_invalidate_execute = 1'b1;
      o_invalidate_memory  = 1'b1;
      o_redirect           = w_trap & ~i_reset;
    end else if (r_state == SLEEP) begin
      o_stall_fetch       = 1'b1;
      o_invalidate_decode = 1'b1;
    end else begin
      o_invalidate_fetch = (r_state == FLUSH);
      if (i_mem_busy) begin
        o_stall_fetch       = 1'b1;
        o_stall_decode      = 1'b1;
        o_stall_execute     = 1'b1;
        o_stall_memory      = 1'b1;
        o_invalidate_memory = 1'b1;
      end else if (w_branch) begin
        o_invalidate_fetch  = 1'b1;
        o_invalidate_decode = 1'b1;
        o_redirect          = 1'b1;
      end else if (w_load_use) begin
        o_stall_fetch        = 1'b1;
        o_stall_decode       = 1'b1;
        o_invalidate_execute = 1'b1;
      end
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, 2, cycles (1..7) that invalidate_fetch stays high after a redirect so in-flight fetches are killed.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 valid_decode  in  1  instruction present at the decode input.
REQ-005 rs1_address_decode / rs2_address_decode  in  5 each  source registers of the decoding instruction.
REQ-006 valid_execute, load_execute  in  1 each  execute stage holds a valid load.
REQ-007 rd_address_execute  in  5  destination of the execute-stage instruction.
REQ-008 branch_taken_execute  in  1  execute resolved a taken branch or jump.
REQ-009 mem_busy  in  1  memory stage is waiting on the bus.
REQ-010 valid_writeback, trap_writeback, mret_writeback, wfi_writeback  in  1 each  writeback retiring an instruction, exception/interrupt, MRET, WFI.
REQ-011 interrupt_pending  in  1  enabled interrupt pending at the CSR unit.
REQ-012 stall_fetch, stall_decode, stall_execute, stall_memory  out  1 each  hold that stage's output registers.
REQ-013 invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory  out  1 each  stage emits a bubble.
REQ-014 redirect  out  1  fetch loads the trap/mret/branch target this cycle.
REQ-015 sleeping  out  1  core is in WFI sleep.

Function
REQ-016 States RUN, FLUSH, SLEEP are held in a register plus a 3-bit flush counter; all stall/invalidate/redirect outputs are combinational from state and inputs.
REQ-017 Priority, highest first: trap/mret, wfi, mem_busy, branch, load-use.
REQ-018 Trap/mret: valid_writeback with trap_writeback or mret_writeback -> same cycle invalidate_fetch..memory=1, redirect=1, stalls=0; next state FLUSH, counter=FLUSH_CYCLES.
REQ-019 FLUSH: invalidate_fetch=1, counter decrements each cycle, return to RUN the cycle after counter reaches 1; a new trap/mret in FLUSH reloads the counter.
REQ-020 WFI: valid_writeback with wfi_writeback and no trap -> invalidate_fetch..memory=1 same cycle, next state SLEEP.
REQ-021 SLEEP: stall_fetch=1, invalidate_decode=1, sleeping=1; interrupt_pending -> next state RUN with redirect=0 (the interrupt is taken through the normal trap path).
REQ-022 mem_busy (not trapping): stall_fetch..stall_memory=1, invalidate_memory=1; branch and load-use are ignored that cycle.
REQ-023 Branch: branch_taken_execute && valid_execute -> invalidate_fetch=1, invalidate_decode=1, redirect=1; no state change.
REQ-024 Load-use: valid_decode && valid_execute && load_execute && rd_address_execute!=0 && rd equals rs1 or rs2 -> stall_fetch=1, stall_decode=1, invalidate_execute=1 for exactly that cycle.
REQ-025 Register x0 never causes a load-use stall.
REQ-026 Branch and load-use in the same cycle -> branch wins; no stall.

Reset
REQ-027 While reset is high: state=RUN, counter=0, invalidate_fetch..memory=1, stalls=0, redirect=0, sleeping=0.
REQ-028 Reset asserted mid-FLUSH or in SLEEP returns the block to RUN at once; after reset deasserts, the first clock edge starts normal operation.

Configuration
REQ-029 KLEINE_WFI_SLEEP_EN defined: SLEEP state is implemented as in REQ-020/021.
REQ-030 KLEINE_WFI_SLEEP_EN undefined: wfi_writeback is ignored, WFI retires as a NOP, sleeping is tied 0, SLEEP is unreachable.

Verification
REQ-031 Load x5 in execute, decode reads rs2=x5 -> one cycle stall_fetch=stall_decode=invalidate_execute=1, then 0; with rd=x0 -> no stall.
REQ-032 Taken branch with load-use the same cycle -> invalidate_fetch=invalidate_decode=redirect=1, stalls=0.
REQ-033 Trap at writeback, FLUSH_CYCLES=2 -> cycle0 all invalidates=1 and redirect=1; cycles 1-2 invalidate_fetch=1; cycle3 state RUN.
REQ-034 WFI retire -> sleeping=1 and stall_fetch=1 held for 10 cycles; interrupt_pending=1 -> sleeping=0 the next cycle; with macro undefined -> sleeping stays 0.
REQ-035 mem_busy=1 for 3 cycles during a branch -> all four stalls=1, redirect=0 until mem_busy=0, then redirect=1.
REQ-036 Reset asserted in FLUSH with counter=1 -> state RUN, invalidates=1 asynchronously before the next clock edge.
